// File: rtl/unified_cache_mem_bridge.sv
// Bridge from the unified cache's to-mem arbiter to a request/ready memory bus.
// One packet is in flight at a time; read data is merged back into the packet and returned.
module unified_cache_mem_bridge #(
    parameter int PACKET_WIDTH   = 164,
    parameter int VALID_POS      = 0,
    parameter int IS_WRITE_POS   = 1,
    parameter int ADDR_LO        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_LO        = 36,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [PACKET_WIDTH-1:0] request_in,
    output logic                    request_ack_out,
    output logic [PACKET_WIDTH-1:0] return_packet_out,
    input  logic                    return_packet_ack_in,
    output logic                    mem_req_valid_out,
    input  logic                    mem_req_ready_in,
    output logic [ADDR_WIDTH-1:0]   mem_addr_out,
    output logic                    mem_we_out,
    output logic [DATA_WIDTH-1:0]   mem_wdata_out,
    input  logic                    mem_resp_valid_in,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
    output logic                    timeout_error_out
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t                  state;
    logic [PACKET_WIDTH-1:0] pkt_reg;
    logic [CNT_W-1:0]        wait_cnt;

    // Merge a data block into a packet; the returned packet is always marked valid.
    function automatic logic [PACKET_WIDTH-1:0] fill_data(
        input logic [PACKET_WIDTH-1:0] pkt,
        input logic [DATA_WIDTH-1:0]   data
    );
        logic [PACKET_WIDTH-1:0] p;
        p = pkt;
        p[DATA_LO +: DATA_WIDTH] = data;
        p[VALID_POS] = 1'b1;
        return p;
    endfunction

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state             <= IDLE;
            pkt_reg           <= '0;
            wait_cnt          <= '0;
            request_ack_out   <= 1'b0;
            return_packet_out <= '0;
            mem_req_valid_out <= 1'b0;
            mem_addr_out      <= '0;
            mem_we_out        <= 1'b0;
            mem_wdata_out     <= '0;
            timeout_error_out <= 1'b0;
        end else begin
            request_ack_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (request_in[VALID_POS]) begin
                        pkt_reg           <= request_in;
                        request_ack_out   <= 1'b1;
                        mem_req_valid_out <= 1'b1;
                        mem_addr_out      <= request_in[ADDR_LO +: ADDR_WIDTH];
                        mem_we_out        <= request_in[IS_WRITE_POS];
                        mem_wdata_out     <= request_in[DATA_LO +: DATA_WIDTH];
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_in) begin
                        mem_req_valid_out <= 1'b0;
                        mem_addr_out      <= '0;
                        mem_we_out        <= 1'b0;
                        mem_wdata_out     <= '0;
                        wait_cnt          <= '0;
                        state             <= pkt_reg[IS_WRITE_POS] ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    // A response on the timeout edge takes priority over the timeout.
                    if (mem_resp_valid_in) begin
                        pkt_reg[DATA_LO +: DATA_WIDTH] <= mem_rdata_in;
                        return_packet_out <= fill_data(pkt_reg, mem_rdata_in);
                        state             <= RETURN;
                    end else if (wait_cnt == CNT_LAST) begin
                        pkt_reg[DATA_LO +: DATA_WIDTH] <= '0;
                        return_packet_out <= fill_data(pkt_reg, '0);
                        timeout_error_out <= 1'b1;
                        state             <= RETURN;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RETURN: begin
                    if (return_packet_ack_in) begin
                        return_packet_out <= '0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_cache_mem_bridge.sv
// Scoreboard bench for unified_cache_mem_bridge: directed packets, expected memory
// requests and return packets are queued and checked by a separate monitor.
module tb_unified_cache_mem_bridge;

    typedef logic [163:0] pkt_t;
    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
    } mem_exp_t;
    typedef struct {
        pkt_t pkt;
        logic err;
    } ret_exp_t;

    logic          clk_in = 1'b0;
    logic          reset_in;
    pkt_t          request_in;
    logic          request_ack_out;
    pkt_t          return_packet_out;
    logic          return_packet_ack_in;
    logic          mem_req_valid_out;
    logic          mem_req_ready_in;
    logic [31:0]   mem_addr_out;
    logic          mem_we_out;
    logic [127:0]  mem_wdata_out;
    logic          mem_resp_valid_in;
    logic [127:0]  mem_rdata_in;
    logic          timeout_error_out;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    mem_exp_t mem_q[$];
    ret_exp_t ret_q[$];

    unified_cache_mem_bridge #(
        .PACKET_WIDTH(164), .VALID_POS(0), .IS_WRITE_POS(1), .ADDR_LO(4),
        .ADDR_WIDTH(32), .DATA_LO(36), .DATA_WIDTH(128), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .request_in(request_in),
        .request_ack_out(request_ack_out),
        .return_packet_out(return_packet_out),
        .return_packet_ack_in(return_packet_ack_in),
        .mem_req_valid_out(mem_req_valid_out),
        .mem_req_ready_in(mem_req_ready_in),
        .mem_addr_out(mem_addr_out),
        .mem_we_out(mem_we_out),
        .mem_wdata_out(mem_wdata_out),
        .mem_resp_valid_in(mem_resp_valid_in),
        .mem_rdata_in(mem_rdata_in),
        .timeout_error_out(timeout_error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [163:0] got, input logic [163:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic pkt_t mk_pkt(input logic v, input logic w, input logic [1:0] port,
                                    input logic [31:0] a, input logic [127:0] d);
        return {d, a, port, w, v};
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input pkt_t p, output int n);
        request_in = p;
        n = 0;
        do begin
            tick();
            n++;
        end while (!request_ack_out && n < 40);
        request_in = '0;
        check("send_ack", request_ack_out, 1);
    endtask

    task automatic wait_ret(output int n);
        n = 0;
        while (!return_packet_out[0] && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Monitor: compare every memory transfer and every accepted return packet.
    always @(negedge clk_in) begin
        if (reset_in) begin
            if (request_ack_out) ack_cnt++;
            if (mem_req_valid_out && mem_req_ready_in) begin
                if (mem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_unexpected: got addr %0h none expected", mem_addr_out);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    check("mem_addr", mem_addr_out, e.addr);
                    check("mem_we", mem_we_out, e.we);
                    check("mem_wdata", mem_wdata_out, e.wdata);
                end
            end
            if (return_packet_out[0] && return_packet_ack_in) begin
                if (ret_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ret_unexpected: got %0h none expected", return_packet_out);
                end else begin
                    ret_exp_t r;
                    r = ret_q.pop_front();
                    check("ret_pkt", return_packet_out, r.pkt);
                    check("ret_err", timeout_error_out, r.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p, exp_ret, stray;
        int n;
        logic [127:0] a5, dead, bp_d, rd2, rd3;
        a5   = {16{8'hA5}};
        dead = {4{32'hDEADBEEF}};
        bp_d = {4{32'hCAFEF00D}};
        rd2  = {4{32'h13572468}};
        rd3  = {4{32'h600DF00D}};

        reset_in = 1'b0;
        request_in = '0;
        return_packet_ack_in = 1'b0;
        mem_req_ready_in = 1'b0;
        mem_resp_valid_in = 1'b0;
        mem_rdata_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_ack", request_ack_out, 0);
        check("rst_mem_valid", mem_req_valid_out, 0);
        check("rst_ret", return_packet_out, 0);
        check("rst_err", timeout_error_out, 0);
        reset_in = 1'b1;
        tick();

        // Writes: back-to-back, second captured two cycles after the first
        mem_req_ready_in = 1'b1;
        mem_q.push_back('{32'h1000, 1'b1, a5});
        send(mk_pkt(1, 1, 2'd2, 32'h1000, a5), n);
        check("wr_ack_lat", n, 1);
        tick();
        check("wr_req_drop", mem_req_valid_out, 0);
        check("wr_ack_pulse", request_ack_out, 0);
        mem_q.push_back('{32'h1010, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677});
        send(mk_pkt(1, 1, 2'd1, 32'h1010, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677), n);
        check("wr2_ack_lat", n, 1);
        tick();
        check("wr_no_ret", return_packet_out, 0);
        check("wr_ack_cnt", ack_cnt, 2);

        // Read with 5-cycle memory latency and return back-pressure
        mem_q.push_back('{32'h2040, 1'b0, 128'h1111});
        exp_ret = mk_pkt(1, 0, 2'd3, 32'h2040, dead);
        ret_q.push_back('{exp_ret, 1'b0});
        send(mk_pkt(1, 0, 2'd3, 32'h2040, 128'h1111), n);
        tick();
        repeat (4) tick();
        mem_resp_valid_in = 1'b1;
        mem_rdata_in = dead;
        tick();
        mem_resp_valid_in = 1'b0;
        mem_rdata_in = '0;
        for (int i = 0; i < 3; i++) begin
            check("rd_hold", return_packet_out, exp_ret);
            tick();
        end
        return_packet_ack_in = 1'b1;
        tick();
        return_packet_ack_in = 1'b0;
        check("rd_clear", return_packet_out, 0);

        // Request back-pressure with a competing valid input
        mem_req_ready_in = 1'b0;
        mem_q.push_back('{32'h3000, 1'b1, bp_d});
        send(mk_pkt(1, 1, 2'd0, 32'h3000, bp_d), n);
        stray = mk_pkt(1, 0, 2'd1, 32'h3333, 128'h0);
        request_in = stray;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", mem_req_valid_out, 1);
            check("bp_addr", mem_addr_out, 32'h3000);
            check("bp_we", mem_we_out, 1);
            check("bp_wdata", mem_wdata_out, bp_d);
            check("bp_no_ack", request_ack_out, 0);
        end
        request_in = '0;
        mem_req_ready_in = 1'b1;
        tick();
        check("bp_done", mem_req_valid_out, 0);
        check("bp_ack_cnt", ack_cnt, 4);

        // Read timeout after 8 WAIT cycles
        mem_q.push_back('{32'h4000, 1'b0, {4{32'h5555AAAA}}});
        ret_q.push_back('{mk_pkt(1, 0, 2'd1, 32'h4000, 128'h0), 1'b1});
        send(mk_pkt(1, 0, 2'd1, 32'h4000, {4{32'h5555AAAA}}), n);
        tick();
        wait_ret(n);
        check("to_wait_cycles", n, 8);
        check("to_err", timeout_error_out, 1);
        return_packet_ack_in = 1'b1;
        tick();
        return_packet_ack_in = 1'b0;

        // Good read; error remains sticky
        mem_q.push_back('{32'h5000, 1'b0, 128'h0});
        ret_q.push_back('{mk_pkt(1, 0, 2'd2, 32'h5000, rd2), 1'b1});
        send(mk_pkt(1, 0, 2'd2, 32'h5000, 128'h0), n);
        tick();
        mem_resp_valid_in = 1'b1;
        mem_rdata_in = rd2;
        tick();
        mem_resp_valid_in = 1'b0;
        check("rd2_valid", return_packet_out[0], 1);
        return_packet_ack_in = 1'b1;
        tick();
        return_packet_ack_in = 1'b0;
        check("err_sticky", timeout_error_out, 1);

        // Asynchronous reset in the middle of WAIT
        mem_q.push_back('{32'h6000, 1'b0, 128'h0});
        send(mk_pkt(1, 0, 2'd3, 32'h6000, 128'h0), n);
        tick();
        repeat (3) tick();
        #2;
        reset_in = 1'b0;
        #1;
        check("arst_ack", request_ack_out, 0);
        check("arst_mem_valid", mem_req_valid_out, 0);
        check("arst_mem_addr", mem_addr_out, 0);
        check("arst_ret", return_packet_out, 0);
        check("arst_err", timeout_error_out, 0);
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        tick();
        mem_resp_valid_in = 1'b1;
        mem_rdata_in = dead;
        return_packet_ack_in = 1'b1;
        tick();
        mem_resp_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_no_ret", return_packet_out, 0);
            tick();
        end
        return_packet_ack_in = 1'b0;

        // Response on the exact timeout edge wins
        mem_q.push_back('{32'h7000, 1'b0, {4{32'h0BADC0DE}}});
        ret_q.push_back('{mk_pkt(1, 0, 2'd0, 32'h7000, rd3), 1'b0});
        send(mk_pkt(1, 0, 2'd0, 32'h7000, {4{32'h0BADC0DE}}), n);
        tick();
        repeat (7) tick();
        check("race_pre_ret", return_packet_out, 0);
        mem_resp_valid_in = 1'b1;
        mem_rdata_in = rd3;
        tick();
        mem_resp_valid_in = 1'b0;
        check("race_err", timeout_error_out, 0);
        return_packet_ack_in = 1'b1;
        tick();
        return_packet_ack_in = 1'b0;
        check("race_clear", return_packet_out, 0);

        tick();
        check("ack_total", ack_cnt, 8);
        check("mem_q_empty", mem_q.size(), 0);
        check("ret_q_empty", ret_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
